// File: rtl/game_input_pkg.sv
// Shared keycode constants, restart FSM states and per-player action payload
// for the frame-rate input decoding path.
package game_input_pkg;

    localparam int unsigned KEY_W = 8;
    localparam int unsigned CNT_W = 4;

    localparam logic [KEY_W-1:0] KEY_BLUE_LEFT  = 8'h0B;
    localparam logic [KEY_W-1:0] KEY_BLUE_RIGHT = 8'h0E;
    localparam logic [KEY_W-1:0] KEY_BLUE_JUMP  = 8'h18;
    localparam logic [KEY_W-1:0] KEY_RED_LEFT   = 8'h50;
    localparam logic [KEY_W-1:0] KEY_RED_RIGHT  = 8'h4F;
    localparam logic [KEY_W-1:0] KEY_RED_JUMP   = 8'h52;
    localparam logic [KEY_W-1:0] KEY_START      = 8'h16;
    localparam logic [KEY_W-1:0] KEY_RESTART    = 8'h28;

    typedef enum logic [1:0] {RS_IDLE, RS_ARM, RS_FIRE, RS_WAIT} restart_state_t;

    typedef struct packed {
        logic left;
        logic right;
        logic jump;
    } player_act_t;

    // Any-of-4 slot compare; an empty slot (8'h00) never produces a hit.
    function automatic logic key_hit(input logic [KEY_W-1:0] k0,
                                     input logic [KEY_W-1:0] k1,
                                     input logic [KEY_W-1:0] k2,
                                     input logic [KEY_W-1:0] k3,
                                     input logic [KEY_W-1:0] code);
        return (code != '0) && ((k0 == code) || (k1 == code) ||
                                (k2 == code) || (k3 == code));
    endfunction

    // Cancels opposing directions and turns a held jump into a one-frame press.
    function automatic player_act_t resolve_act(input player_act_t snap,
                                                input logic prev_jump);
        player_act_t r;
        r.left  = snap.left  & ~snap.right;
        r.right = snap.right & ~snap.left;
        r.jump  = snap.jump  & ~prev_jump;
        return r;
    endfunction

endpackage

// File: rtl/vs_edge_sync.sv
// Brings the asynchronous vsync into the clock domain and emits a registered
// one-cycle pulse on each of its rising edges.
module vs_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic vs,
    output logic frame_tick
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic dly_q,   dly_d;
    logic tick_q,  tick_d;

    always_comb begin
        sync1_d = vs;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
        tick_d  = sync2_q & ~dly_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dly_q   <= dly_d;
            tick_q  <= tick_d;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/player_input_decoder.sv
// Turns the four raw keycode slots into per-frame player action strobes and
// start/restart requests, published once per synchronised vsync rising edge.
module player_input_decoder
    import game_input_pkg::*;
#(
    parameter int unsigned HOLD_FRAMES = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             vs,
    input  logic [KEY_W-1:0] keycode0,
    input  logic [KEY_W-1:0] keycode1,
    input  logic [KEY_W-1:0] keycode2,
    input  logic [KEY_W-1:0] keycode3,
    output logic             frame_tick,
    output logic             blue_left,
    output logic             blue_right,
    output logic             blue_jump,
    output logic             red_left,
    output logic             red_right,
    output logic             red_jump,
    output logic             start_req,
    output logic             restart_req
);

    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_FRAMES);

    player_act_t    blue_hit, red_hit, blue_snap, red_snap;
    logic           start_hit, enter_hit, start_snap, enter_snap;

    player_act_t    blue_acc_q, blue_acc_d, red_acc_q, red_acc_d;
    logic           start_acc_q, start_acc_d, enter_acc_q, enter_acc_d;

    player_act_t    blue_out_q, blue_out_d, red_out_q, red_out_d;
    logic           blue_jprev_q, blue_jprev_d, red_jprev_q, red_jprev_d;
    logic           start_q, start_d, restart_q, restart_d;

    restart_state_t rs_q, rs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    vs_edge_sync u_vs_sync (
        .clk        (Clk),
        .rst        (Reset),
        .vs         (vs),
        .frame_tick (frame_tick)
    );

    // Key matching, sticky accumulation and per-frame snapshot of the action outputs.
    always_comb begin
        blue_hit       = '0;
        red_hit        = '0;
        blue_hit.left  = key_hit(keycode0, keycode1, keycode2, keycode3, KEY_BLUE_LEFT);
        blue_hit.right = key_hit(keycode0, keycode1, keycode2, keycode3, KEY_BLUE_RIGHT);
        blue_hit.jump  = key_hit(keycode0, keycode1, keycode2, keycode3, KEY_BLUE_JUMP);
        red_hit.left   = key_hit(keycode0, keycode1, keycode2, keycode3, KEY_RED_LEFT);
        red_hit.right  = key_hit(keycode0, keycode1, keycode2, keycode3, KEY_RED_RIGHT);
        red_hit.jump   = key_hit(keycode0, keycode1, keycode2, keycode3, KEY_RED_JUMP);
        start_hit      = key_hit(keycode0, keycode1, keycode2, keycode3, KEY_START);
        enter_hit      = key_hit(keycode0, keycode1, keycode2, keycode3, KEY_RESTART);

        blue_snap  = blue_acc_q | blue_hit;
        red_snap   = red_acc_q  | red_hit;
        start_snap = start_acc_q | start_hit;
        enter_snap = enter_acc_q | enter_hit;

        blue_acc_d   = blue_snap;
        red_acc_d    = red_snap;
        start_acc_d  = start_snap;
        enter_acc_d  = enter_snap;
        blue_out_d   = blue_out_q;
        red_out_d    = red_out_q;
        blue_jprev_d = blue_jprev_q;
        red_jprev_d  = red_jprev_q;
        start_d      = start_q;

        // The tick-cycle keys land in this snapshot only, so the next frame starts empty.
        if (frame_tick) begin
            blue_acc_d   = '0;
            red_acc_d    = '0;
            start_acc_d  = 1'b0;
            enter_acc_d  = 1'b0;
            blue_out_d   = resolve_act(blue_snap, blue_jprev_q);
            red_out_d    = resolve_act(red_snap, red_jprev_q);
            blue_jprev_d = blue_snap.jump;
            red_jprev_d  = red_snap.jump;
            start_d      = start_snap;
        end
    end

    // Restart hold FSM; advances only on frame ticks using the Enter snapshot.
    always_comb begin
        rs_d      = rs_q;
        cnt_d     = cnt_q;
        restart_d = restart_q;
        if (frame_tick) begin
            case (rs_q)
                RS_IDLE: begin
                    if (enter_snap) begin
                        cnt_d = CNT_W'(1);
                        rs_d  = (HOLD_C == CNT_W'(1)) ? RS_FIRE : RS_ARM;
                    end
                end
                RS_ARM: begin
                    if (!enter_snap) begin
                        rs_d  = RS_IDLE;
                        cnt_d = '0;
                    end else if (CNT_W'(cnt_q + CNT_W'(1)) == HOLD_C) begin
                        rs_d  = RS_FIRE;
                        cnt_d = HOLD_C;
                    end else begin
                        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    end
                end
                RS_FIRE: begin
                    rs_d = enter_snap ? RS_WAIT : RS_IDLE;
                    if (!enter_snap) cnt_d = '0;
                end
                RS_WAIT: begin
                    if (!enter_snap) begin
                        rs_d  = RS_IDLE;
                        cnt_d = '0;
                    end
                end
                default: begin
                    rs_d  = RS_IDLE;
                    cnt_d = '0;
                end
            endcase
            restart_d = (rs_d == RS_FIRE);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            blue_acc_q   <= '0;
            red_acc_q    <= '0;
            start_acc_q  <= 1'b0;
            enter_acc_q  <= 1'b0;
            blue_out_q   <= '0;
            red_out_q    <= '0;
            blue_jprev_q <= 1'b0;
            red_jprev_q  <= 1'b0;
            start_q      <= 1'b0;
            restart_q    <= 1'b0;
            rs_q         <= RS_IDLE;
            cnt_q        <= '0;
        end else begin
            blue_acc_q   <= blue_acc_d;
            red_acc_q    <= red_acc_d;
            start_acc_q  <= start_acc_d;
            enter_acc_q  <= enter_acc_d;
            blue_out_q   <= blue_out_d;
            red_out_q    <= red_out_d;
            blue_jprev_q <= blue_jprev_d;
            red_jprev_q  <= red_jprev_d;
            start_q      <= start_d;
            restart_q    <= restart_d;
            rs_q         <= rs_d;
            cnt_q        <= cnt_d;
        end
    end

    assign blue_left   = blue_out_q.left;
    assign blue_right  = blue_out_q.right;
    assign blue_jump   = blue_out_q.jump;
    assign red_left    = red_out_q.left;
    assign red_right   = red_out_q.right;
    assign red_jump    = red_out_q.jump;
    assign start_req   = start_q;
    assign restart_req = restart_q;

endmodule
